// File: rtl/fifo_pkg.sv
// Shared types and helpers for the level-tracking FIFO controller.
package fifo_pkg;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_status_t;

  // Level must hold 0..DEPTH, and DEPTH can equal 2**ADDR_WIDTH.
  function automatic int unsigned lvl_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Pointer register that wraps DEPTH-1 -> 0 when incremented; DEPTH need not be a power of two.
module fifo_ptr #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] ptr_o
);

  localparam logic [ADDR_WIDTH-1:0] PtrLast = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == PtrLast) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl_lvl.sv
// FIFO controller tracking occupancy with a level counter and threshold flags.
// Define FIFO_CTRL_ERR_EN to build the sticky overflow/underflow flags.
module fifo_ctrl_lvl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH,
  parameter int unsigned AE_THRESH  = 2,
  parameter int unsigned AF_THRESH  = DEPTH - 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr,
  input  logic                                rd,
  input  logic                                clr_err,
  output logic                                wr_en,
  output logic                                rd_en,
  output logic [ADDR_WIDTH-1:0]               w_addr,
  output logic [ADDR_WIDTH-1:0]               r_addr,
  output logic                                empty,
  output logic                                full,
  output logic                                almost_empty,
  output logic                                almost_full,
  output logic [lvl_width(ADDR_WIDTH)-1:0]    level,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int unsigned LvlW = lvl_width(ADDR_WIDTH);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);
  localparam logic [LvlW-1:0] LvlAe   = LvlW'(AE_THRESH);
  localparam logic [LvlW-1:0] LvlAf   = LvlW'(AF_THRESH);

  logic [LvlW-1:0] level_q, level_d;
  fifo_status_t    status;

  // Flags derive only from registered level, never from rd/wr.
  always_comb begin
    status.empty        = (level_q == '0);
    status.full         = (level_q == LvlFull);
    status.almost_empty = (level_q <= LvlAe);
    status.almost_full  = (level_q >= LvlAf);
  end

  // A read frees a slot, so a write into a full FIFO succeeds alongside it.
  assign wr_en = wr & (~status.full | rd);
  assign rd_en = rd & ~status.empty;

  always_comb begin
    level_d = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  fifo_ptr #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_wr_ptr (
    .clk  (clk),
    .rst  (rst),
    .inc_i(wr_en),
    .ptr_o(w_addr)
  );

  fifo_ptr #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_rd_ptr (
    .clk  (clk),
    .rst  (rst),
    .inc_i(rd_en),
    .ptr_o(r_addr)
  );

  assign empty        = status.empty;
  assign full         = status.full;
  assign almost_empty = status.almost_empty;
  assign almost_full  = status.almost_full;
  assign level        = level_q;

`ifdef FIFO_CTRL_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // A new error in the same cycle as clr_err takes priority over the clear.
  always_comb begin
    ovf_d = clr_err ? 1'b0 : ovf_q;
    udf_d = clr_err ? 1'b0 : udf_q;
    if (wr & status.full & ~rd) ovf_d = 1'b1;
    if (rd & status.empty)      udf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule
